// File: rtl/result_display_driver.sv
// Binary-to-BCD display driver: sequential double-dabble converter feeding a
// five-digit multiplexed common-anode 7-segment scanner.
module result_display_driver #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLANK_LZ    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd,
    output logic [4:0]  an,
    output logic [6:0]  seg
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [15:0] last_val;
    logic [15:0] src;
    logic [19:0] scratch;
    logic [3:0]  iter;
    logic        load;
    logic        step;
    logic        commit;

    logic [19:0] adj;
    logic [35:0] shifted;

    logic [CW-1:0] ref_cnt;
    logic [2:0]    idx;
    logic [3:0]    digit;
    logic          lead_zero;
    logic [4:0]    an_nxt;
    logic [6:0]    seg_nxt;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (value != last_val) begin
                    load      = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                step = 1'b1;
                if (iter == 4'd15) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // One double-dabble iteration: correct every BCD nibble, then shift.
    always_comb begin
        adj = scratch;
        for (int unsigned i = 0; i < 5; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj, src} << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_val <= '0;
            src      <= '0;
            scratch  <= '0;
            iter     <= '0;
            bcd      <= '0;
            done     <= 1'b0;
        end else begin
            done <= commit;
            if (load) begin
                src      <= value;
                last_val <= value;
                scratch  <= '0;
                iter     <= '0;
            end
            if (step) begin
                scratch <= shifted[35:16];
                src     <= shifted[15:0];
                iter    <= iter + 4'd1;
            end
            if (commit) begin
                bcd <= scratch;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt <= '0;
            idx     <= '0;
        end else if (ref_cnt == REF_LAST) begin
            ref_cnt <= '0;
            idx     <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    // A digit is a leading zero when it and every more significant digit are zero.
    always_comb begin
        digit     = bcd[3:0];
        lead_zero = 1'b0;
        case (idx)
            3'd1: begin
                digit     = bcd[7:4];
                lead_zero = (bcd[19:4] == '0);
            end
            3'd2: begin
                digit     = bcd[11:8];
                lead_zero = (bcd[19:8] == '0);
            end
            3'd3: begin
                digit     = bcd[15:12];
                lead_zero = (bcd[19:12] == '0);
            end
            3'd4: begin
                digit     = bcd[19:16];
                lead_zero = (bcd[19:16] == '0);
            end
            default: begin
                digit     = bcd[3:0];
                lead_zero = 1'b0;
            end
        endcase
        an_nxt  = ~(5'd1 << idx);
        seg_nxt = ((BLANK_LZ != 0) && lead_zero) ? 7'b1111111 : seg_code(digit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 5'b11110;
            seg <= 7'b1000000;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule

// File: doc/result_display_driver.md
Name: result_display_driver

Overview:
- Downstream consumer of the calculator FSM's 16-bit `result` bus; drives a 5-digit multiplexed common-anode 7-segment display.
- Converts the unsigned binary value to BCD with a sequential double-dabble engine (one shift per clock).
- Time-multiplexes the five digits, with optional leading-zero blanking.
- Conversion restarts automatically whenever the input value changes.

Parameters:
- REFRESH_DIV, 50000: clocks per digit slot in the scan; legal range ≥ 2.
- BLANK_LZ, 1: 1 = blank leading zeros; 0 = show all five digits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- value  input  16  unsigned binary to display (calculator `result`).
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when `bcd` is updated.
- bcd  output  20  registered BCD digits: [19:16] is the ten-thousands digit, [3:0] is the units digit.
- an  output  5  digit enables, active-low, one-hot; an[0] selects the units digit.
- seg  output  7  segments, active-low, ordered {g,f,e,d,c,b,a}.

Behaviour:
- Reset (async assert, rst_n low), all of the following take effect immediately:
  - busy=0, done=0, bcd=0.
  - Internal last_val=0, scan index=0, refresh counter=0.
  - an=5'b11110, seg=7'b1000000 (the display shows "0").
  - Release of rst_n is sampled synchronously on the next clk edge.
- Converter FSM, states IDLE, CONV, DONE:
  - IDLE: if value != last_val, then:
    - capture src<=value and last_val<=value;
    - clear the 20-bit scratch and the 4-bit iteration counter;
    - go to CONV.
    - Otherwise stay in IDLE.
  - CONV: each cycle, on the combined {scratch, src} register:
    - add 3 to every scratch nibble ≥ 5;
    - then shift the combined register left by 1;
    - increment the counter.
    - After the 16th shift (counter==15), go to DONE.
  - DONE: bcd<=scratch, done=1 for this cycle only, go to IDLE.
  - busy=1 in CONV and DONE, 0 in IDLE.
- Latency: with E = the edge that captures a new value, bcd holds the result and done is high after edge E+17. Throughput is one conversion per 18 cycles.
- Value changing during CONV/DONE:
  - No effect on the conversion in flight; the old src is used.
  - On return to IDLE the compare against last_val triggers a fresh conversion, so bcd always converges to the final stable value.
- Value returning to last_val before IDLE is re-entered: no further conversion.
- Maximum input 65535 gives bcd=20'h65535; no overflow is possible with 5 digits.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1, then wraps to 0 and advances the scan index 0→1→2→3→4→0.
  - an = ~(1<<index), registered.
  - seg = encoding of bcd nibble[index], registered in the same cycle as an, so an and seg are never misaligned.
- Segment codes (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - nibble >9 = 1111111 (unreachable).
- Leading-zero blanking (BLANK_LZ=1): digit i>0 drives seg=7'b1111111 when bcd nibbles i..4 are all zero. Digit 0 is never blanked.
- Display source is `bcd` only; the display never shows partial scratch contents.

Test Plan:
- Reset with value=0 → busy=0, bcd=0, an=5'b11110, seg=7'b1000000; no done pulse for 100 cycles.
- value 0→12345 → busy rises after the capture edge; done pulses exactly 17 cycles after capture; bcd=20'h12345.
- value=65535 → bcd=20'h65535. value=9 → bcd=20'h00009, and with BLANK_LZ=1 digits 1–4 show seg=7'b1111111 while digit 0 shows 0010000.
- value=100, then value=200 on the 5th cycle of CONV → first done gives bcd=20'h00100; a second conversion follows automatically and its done gives 20'h00200; exactly two done pulses.
- REFRESH_DIV=4, value=54321, BLANK_LZ=0:
  - an steps 11110→11101→11011→10111→01111→11110, each held for 4 clocks;
  - seg in those slots is 1111001, 0100100, 0110000, 0011001, 0010010.
- rst_n pulled low mid-CONV (value=999) → bcd=0, busy=0 immediately. After release, value 999 ≠ last_val 0 triggers a conversion, ending with bcd=20'h00999.
